rdi_sb_resp_engine: RTL and testbench

- Parametrised successor to the single-shot RDI bring-up RX responder.
- Accepts partner sideband state-request messages and queues them in a DEPTH-entry FIFO.
- For each queued request it builds the matching response (or PM_NAK) and drives it to the TX sideband with a valid/done handshake and a timeout.
- Sits between the RX sideband decoder and the TX sideband mux inside the RDI controller.

---
 rtl/rdi_msg_pkg.sv | 46 ++++
 rtl/rdi_req_fifo.sv | 75 +++++++
 rtl/rdi_sb_resp_engine.sv | 188 ++++++++++++++++++
 tb/tb_rdi_sb_resp_engine.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdi_msg_pkg.sv
// rtl/rdi_msg_pkg.sv - sideband message codes, request-to-response map, responder FSM states
package rdi_msg_pkg;

  localparam logic [3:0] ACTIVE_REQ    = 4'd1;
  localparam logic [3:0] L1_REQ        = 4'd2;
  localparam logic [3:0] L2_REQ        = 4'd3;
  localparam logic [3:0] LINKRESET_REQ = 4'd4;
  localparam logic [3:0] LINKERROR_REQ = 4'd5;
  localparam logic [3:0] RETRAIN_REQ   = 4'd6;
  localparam logic [3:0] DISABLE_REQ   = 4'd7;

  localparam logic [3:0] ACTIVE_RSP    = 4'd8;
  localparam logic [3:0] PM_NAK        = 4'd9;
  localparam logic [3:0] L1_RSP        = 4'd10;
  localparam logic [3:0] L2_RSP        = 4'd11;
  localparam logic [3:0] LINKRESET_RSP = 4'd12;
  localparam logic [3:0] LINKERROR_RSP = 4'd13;
  localparam logic [3:0] RETRAIN_RSP   = 4'd14;
  localparam logic [3:0] DISABLE_RSP   = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_DONE,
    ST_DONE
  } resp_state_e;

  // Power-management requests are refused with PM_NAK unless the local side allows them.
  function automatic logic [3:0] map_req_to_rsp(input logic [2:0] req, input logic pm_allow);
    logic [3:0] rsp;
    rsp = ACTIVE_RSP;
    case (req)
      ACTIVE_REQ[2:0]:    rsp = ACTIVE_RSP;
      L1_REQ[2:0]:        rsp = pm_allow ? L1_RSP : PM_NAK;
      L2_REQ[2:0]:        rsp = pm_allow ? L2_RSP : PM_NAK;
      LINKRESET_REQ[2:0]: rsp = LINKRESET_RSP;
      LINKERROR_REQ[2:0]: rsp = LINKERROR_RSP;
      RETRAIN_REQ[2:0]:   rsp = RETRAIN_RSP;
      DISABLE_REQ[2:0]:   rsp = DISABLE_RSP;
      default:            rsp = ACTIVE_RSP;
    endcase
    return rsp;
  endfunction

endpackage

// File: rtl/rdi_req_fifo.sv
// rtl/rdi_req_fifo.sv - synchronous request FIFO with flush and single-entry replace
// Ports:
//   lclk, sys_rst    clock, asynchronous active-low reset
//   flush            empty the FIFO (highest priority)
//   replace          drop all entries and write push_data as the sole entry
//   push, push_data  enqueue (ignored when full)
//   pop              dequeue the head (ignored when empty)
//   head             current head entry
//   full, empty      status
//   count            occupancy, registered
module rdi_req_fifo
  import rdi_msg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MSG_W = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             lclk,
  input  logic             sys_rst,
  input  logic             flush,
  input  logic             replace,
  input  logic             push,
  input  logic [MSG_W-1:0] push_data,
  input  logic             pop,
  output logic [MSG_W-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [MSG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // Full is judged before any same-cycle pop, so a pop never makes room for a push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (replace) begin
      rd_ptr <= '0;
      wr_ptr <= PTR_W'(1);
      count  <= (PTR_W+1)'(1);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge lclk) begin
    if (!flush) begin
      if (replace)      mem[0]      <= push_data;
      else if (do_push) mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/rdi_sb_resp_engine.sv
// rtl/rdi_sb_resp_engine.sv - queued sideband state-request responder with TX handshake and timeout
// Ports:
//   lclk, sys_rst            clock, asynchronous active-low reset
//   i_enable                 engine enable; low flushes the queue and idles the FSM
//   i_clr_flags              clears o_overflow / o_timeout (a same-cycle set wins)
//   i_rx_sb_message          received sideband code, qualified by i_rx_msg_valid
//   i_req_accept_mask        bit k-1 enables request code k
//   i_pm_allow               grant L1/L2 (1) or answer PM_NAK (0), sampled on load
//   i_tx_busy                TX sideband busy, holds off a new send
//   i_tx_done_send_message   TX finished the current message
//   o_tx_sb_message          response code, o_tx_msg_valid qualifies it
//   o_resp_done, o_resp_code one-cycle completion pulse and held completed code
//   o_rejected               one-cycle pulse for a masked request
//   o_pending                queue occupancy
//   o_overflow, o_timeout    sticky error flags
module rdi_sb_resp_engine
  import rdi_msg_pkg::*;
#(
  parameter int MSG_W       = 4,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int PTR_W       = $clog2(DEPTH)
) (
  input  logic             lclk,
  input  logic             sys_rst,
  input  logic             i_enable,
  input  logic             i_clr_flags,
  input  logic [MSG_W-1:0] i_rx_sb_message,
  input  logic             i_rx_msg_valid,
  input  logic [6:0]       i_req_accept_mask,
  input  logic             i_pm_allow,
  input  logic             i_tx_busy,
  input  logic             i_tx_done_send_message,
  output logic [MSG_W-1:0] o_tx_sb_message,
  output logic             o_tx_msg_valid,
  output logic             o_resp_done,
  output logic [MSG_W-1:0] o_resp_code,
  output logic             o_rejected,
  output logic [PTR_W:0]   o_pending,
  output logic             o_overflow,
  output logic             o_timeout
);

  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  resp_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q;
  logic [MSG_W-1:0] resp_q;

  logic [MSG_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;

  logic             is_req;
  logic             is_linkerr;
  logic             mask_hit;
  logic             push_try;
  logic             fifo_push;
  logic             fifo_replace;
  logic             reject_set;
  logic             ovf_set;

  logic             pop;
  logic             load_resp;
  logic             start_send;
  logic             timer_inc;
  logic             tmo_set;

  // Request decode; anything outside 1..7 is silently ignored.
  assign is_req     = (i_rx_sb_message != '0) && (i_rx_sb_message < MSG_W'(8));
  assign is_linkerr = (i_rx_sb_message == MSG_W'(LINKERROR_REQ));
  assign mask_hit   = i_req_accept_mask[i_rx_sb_message[2:0] - 3'd1];
  assign push_try   = i_enable && i_rx_msg_valid && is_req && mask_hit;
  assign reject_set = i_enable && i_rx_msg_valid && is_req && !mask_hit;

  // LINKERROR always preempts the backlog, so it can never overflow.
  assign fifo_replace = push_try && is_linkerr;
  assign fifo_push    = push_try && !is_linkerr;
  assign ovf_set      = fifo_push && fifo_full;

  rdi_req_fifo #(
    .DEPTH (DEPTH),
    .MSG_W (MSG_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .lclk      (lclk),
    .sys_rst   (sys_rst),
    .flush     (!i_enable),
    .replace   (fifo_replace),
    .push      (fifo_push),
    .push_data (i_rx_sb_message),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_pending)
  );

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    load_resp  = 1'b0;
    start_send = 1'b0;
    timer_inc  = 1'b0;
    tmo_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pop       = 1'b1;
        load_resp = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (!i_tx_busy) begin
          start_send = 1'b1;
          state_d    = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_tx_done_send_message) begin
          state_d = ST_DONE;
        end else if (timer_q == TMR_LAST) begin
          tmo_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (!i_enable) begin
      state_d    = ST_IDLE;
      pop        = 1'b0;
      load_resp  = 1'b0;
      start_send = 1'b0;
      timer_inc  = 1'b0;
      tmo_set    = 1'b0;
    end
  end

  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      resp_q          <= '0;
      o_tx_sb_message <= '0;
      o_tx_msg_valid  <= 1'b0;
      o_resp_done     <= 1'b0;
      o_resp_code     <= '0;
      o_rejected      <= 1'b0;
      o_overflow      <= 1'b0;
      o_timeout       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (load_resp) resp_q <= MSG_W'(map_req_to_rsp(fifo_head[2:0], i_pm_allow));

      if (start_send) begin
        timer_q         <= '0;
        o_tx_sb_message <= resp_q;
      end else if (timer_inc) begin
        timer_q <= timer_q + TMR_W'(1);
      end

      // Outputs follow the next state so they are registered yet aligned with it.
      o_tx_msg_valid <= (state_d == ST_WAIT_DONE);
      o_resp_done    <= (state_d == ST_DONE);
      if (state_d == ST_DONE) o_resp_code <= resp_q;

      o_rejected <= reject_set;

      if (ovf_set)          o_overflow <= 1'b1;
      else if (i_clr_flags) o_overflow <= 1'b0;

      if (tmo_set)          o_timeout <= 1'b1;
      else if (i_clr_flags) o_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rdi_sb_resp_engine.sv
// tb/tb_rdi_sb_resp_engine.sv - directed self-checking bench for rdi_sb_resp_engine
module tb_rdi_sb_resp_engine;

  logic       lclk;
  logic       sys_rst;
  logic       i_enable;
  logic       i_clr_flags;
  logic [3:0] i_rx_sb_message;
  logic       i_rx_msg_valid;
  logic [6:0] i_req_accept_mask;
  logic       i_pm_allow;
  logic       i_tx_busy;
  logic       i_tx_done_send_message;
  logic [3:0] o_tx_sb_message;
  logic       o_tx_msg_valid;
  logic       o_resp_done;
  logic [3:0] o_resp_code;
  logic       o_rejected;
  logic [2:0] o_pending;
  logic       o_overflow;
  logic       o_timeout;

  int tests = 0;
  int fails = 0;

  rdi_sb_resp_engine #(
    .MSG_W       (4),
    .DEPTH       (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .lclk                   (lclk),
    .sys_rst                (sys_rst),
    .i_enable               (i_enable),
    .i_clr_flags            (i_clr_flags),
    .i_rx_sb_message        (i_rx_sb_message),
    .i_rx_msg_valid         (i_rx_msg_valid),
    .i_req_accept_mask      (i_req_accept_mask),
    .i_pm_allow             (i_pm_allow),
    .i_tx_busy              (i_tx_busy),
    .i_tx_done_send_message (i_tx_done_send_message),
    .o_tx_sb_message        (o_tx_sb_message),
    .o_tx_msg_valid         (o_tx_msg_valid),
    .o_resp_done            (o_resp_done),
    .o_resp_code            (o_resp_code),
    .o_rejected             (o_rejected),
    .o_pending              (o_pending),
    .o_overflow             (o_overflow),
    .o_timeout              (o_timeout)
  );

  initial lclk = 1'b0;
  always #5 lclk = ~lclk;

  typedef struct {
    logic       rxv;
    logic [3:0] msg;
    logic       busy;
    logic       done;
    logic       exp_valid;
    logic [3:0] exp_msg;
    logic       exp_rdone;
    logic [3:0] exp_rcode;
    logic [2:0] exp_pend;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge lclk);
    #1;
  endtask

  task automatic push(input logic [3:0] code);
    i_rx_msg_valid  = 1'b1;
    i_rx_sb_message = code;
    step();
    i_rx_msg_valid  = 1'b0;
    i_rx_sb_message = 4'd0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!o_tx_msg_valid && n < 40) begin
      step();
      n++;
    end
    chk("wait_valid", 32'(o_tx_msg_valid), 32'd1);
  endtask

  task automatic serve(input logic [3:0] exp_code);
    wait_valid();
    chk("serve_code", 32'(o_tx_sb_message), 32'(exp_code));
    step();
    i_tx_done_send_message = 1'b1;
    step();
    i_tx_done_send_message = 1'b0;
    chk("serve_rdone", 32'(o_resp_done), 32'd1);
    chk("serve_rcode", 32'(o_resp_code), 32'(exp_code));
    chk("serve_vdrop", 32'(o_tx_msg_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic saw_done;

    sys_rst = 1'b0;
    i_enable = 1'b1;
    i_clr_flags = 1'b0;
    i_rx_sb_message = 4'd0;
    i_rx_msg_valid = 1'b0;
    i_req_accept_mask = 7'h7F;
    i_pm_allow = 1'b1;
    i_tx_busy = 1'b0;
    i_tx_done_send_message = 1'b0;

    // ACTIVE_REQ flow, cycle by cycle; done in the SEND cycle must be ignored.
    //         rxv   msg    busy  done  valid emsg   rdone rcode  pend
    tbl[0] = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 3'd1};
    tbl[1] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 3'd1};
    tbl[2] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 3'd0};
    tbl[3] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd8, 1'b0, 4'd0, 3'd0};
    tbl[4] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 4'd0, 3'd0};
    tbl[5] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0, 4'd0, 3'd0};
    tbl[6] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 4'd0, 3'd0};
    tbl[7] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd8, 3'd0};
    tbl[8] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd8, 3'd0};

    repeat (3) @(posedge lclk);
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_valid", 32'(o_tx_msg_valid), 32'd0);
    chk("rst_msg", 32'(o_tx_sb_message), 32'd0);
    chk("rst_rdone", 32'(o_resp_done), 32'd0);
    chk("rst_rcode", 32'(o_resp_code), 32'd0);
    chk("rst_rej", 32'(o_rejected), 32'd0);
    chk("rst_pend", 32'(o_pending), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_tmo", 32'(o_timeout), 32'd0);
    step();

    for (int i = 0; i < 9; i++) begin
      i_rx_msg_valid = tbl[i].rxv;
      i_rx_sb_message = tbl[i].msg;
      i_tx_busy = tbl[i].busy;
      i_tx_done_send_message = tbl[i].done;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(o_tx_msg_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid)
        chk($sformatf("tbl%0d_msg", i), 32'(o_tx_sb_message), 32'(tbl[i].exp_msg));
      chk($sformatf("tbl%0d_rdone", i), 32'(o_resp_done), 32'(tbl[i].exp_rdone));
      chk($sformatf("tbl%0d_rcode", i), 32'(o_resp_code), 32'(tbl[i].exp_rcode));
      chk($sformatf("tbl%0d_pend", i), 32'(o_pending), 32'(tbl[i].exp_pend));
    end
    i_rx_msg_valid = 1'b0;
    i_tx_busy = 1'b0;
    i_tx_done_send_message = 1'b0;
    step();

    // PM grant/nak: L1, L2 with pm_allow=0, then L1 with pm_allow=1.
    i_pm_allow = 1'b0;
    i_tx_busy = 1'b1;
    push(4'd2);
    push(4'd3);
    push(4'd2);
    i_tx_busy = 1'b0;
    serve(4'd9);
    serve(4'd9);
    i_pm_allow = 1'b1;
    serve(4'd10);
    repeat (3) step();
    chk("pm_pend", 32'(o_pending), 32'd0);

    // Overflow: one in flight held by busy, then five RETRAIN pushes.
    i_tx_busy = 1'b1;
    push(4'd1);
    repeat (3) step();
    chk("ovf_pre_pend", 32'(o_pending), 32'd0);
    for (int i = 0; i < 5; i++) push(4'd6);
    chk("ovf_pend", 32'(o_pending), 32'd4);
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    i_clr_flags = 1'b1;
    step();
    i_clr_flags = 1'b0;
    chk("ovf_clr", 32'(o_overflow), 32'd0);
    i_clr_flags = 1'b1;
    push(4'd6);
    i_clr_flags = 1'b0;
    chk("ovf_set_wins", 32'(o_overflow), 32'd1);
    i_enable = 1'b0;
    step();
    chk("dis_pend", 32'(o_pending), 32'd0);
    chk("dis_valid", 32'(o_tx_msg_valid), 32'd0);
    chk("dis_keep_ovf", 32'(o_overflow), 32'd1);
    i_enable = 1'b1;
    i_tx_busy = 1'b0;
    i_clr_flags = 1'b1;
    step();
    i_clr_flags = 1'b0;
    chk("ovf_clr2", 32'(o_overflow), 32'd0);

    // LINKERROR preemption with DISABLE in flight and three queued.
    for (int i = 0; i < 4; i++) push(4'd7);
    chk("le_inflight", 32'(o_tx_msg_valid), 32'd1);
    chk("le_pend3", 32'(o_pending), 32'd3);
    push(4'd5);
    chk("le_pend1", 32'(o_pending), 32'd1);
    serve(4'd15);
    serve(4'd13);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_tx_msg_valid) n++;
    end
    chk("le_idle_valid", 32'(n), 32'd0);
    chk("le_pend0", 32'(o_pending), 32'd0);

    // Timeout: valid held exactly 16 cycles, no done pulse, next request served.
    push(4'd1);
    push(4'd1);
    wait_valid();
    n = 0;
    saw_done = 1'b0;
    while (o_tx_msg_valid && n < 40) begin
      n++;
      step();
      if (o_resp_done) saw_done = 1'b1;
    end
    chk("tmo_len", 32'(n), 32'd16);
    chk("tmo_flag", 32'(o_timeout), 32'd1);
    chk("tmo_nodone", 32'(saw_done), 32'd0);
    serve(4'd8);
    i_clr_flags = 1'b1;
    step();
    i_clr_flags = 1'b0;
    chk("tmo_clr", 32'(o_timeout), 32'd0);

    // Masked LINKRESET is rejected; out-of-range codes are ignored.
    i_req_accept_mask = 7'h77;
    push(4'd4);
    chk("rej_pulse", 32'(o_rejected), 32'd1);
    chk("rej_pend", 32'(o_pending), 32'd0);
    step();
    chk("rej_once", 32'(o_rejected), 32'd0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_tx_msg_valid) n++;
    end
    chk("rej_nosend", 32'(n), 32'd0);
    push(4'd0);
    chk("ign0_pend", 32'(o_pending), 32'd0);
    chk("ign0_rej", 32'(o_rejected), 32'd0);
    push(4'd12);
    chk("ign12_pend", 32'(o_pending), 32'd0);
    chk("ign12_rej", 32'(o_rejected), 32'd0);
    i_req_accept_mask = 7'h7F;

    // Enable dropped mid WAIT_DONE.
    push(4'd6);
    push(4'd6);
    wait_valid();
    step();
    step();
    i_enable = 1'b0;
    step();
    chk("en_valid", 32'(o_tx_msg_valid), 32'd0);
    chk("en_pend", 32'(o_pending), 32'd0);
    push(4'd1);
    chk("en_nopush", 32'(o_pending), 32'd0);
    i_enable = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_tx_msg_valid || o_resp_done) n++;
    end
    chk("en_quiet", 32'(n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
